// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin flip-flop bank arbiter: state
// encoding, index-width helper and pointer reset value.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NREQ_DEFAULT = 4;
  localparam int IDX_W        = $clog2(NREQ_DEFAULT);

  // Index width for a given requester count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The pointer resets to the last index so that requester 0 wins first.
  function automatic int ptr_reset(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1, wrapping,
// and reports the first active request.
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin owner of a shared WIDTH-bit register: one write per
// req/gnt/ack transaction, gnt and ack driven straight from flops.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IW    = idx_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic [IW-1:0]         owner,
  output logic [1:0]            fsm_state
);

  localparam logic [IW-1:0] PTR_RST = IW'(ptr_reset(NREQ));

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("dff_bank_arbiter: NREQ must be within 2..8");
  end

  // Handshake: a requester holds req until it sees ack; gnt marks the one
  // cycle in which req[owner] is sampled to decide commit versus abort.
  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner;
  logic            pick_valid;
  logic            owner_req;
  logic [NREQ-1:0] gnt_next;
  logic [NREQ-1:0] ack_next;

  assign owner_req = req[owner];

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = pick_valid ? GRANT : IDLE;
      GRANT:   state_next = owner_req ? COMMIT : IDLE;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // GRANT is only entered from IDLE and COMMIT only from GRANT, so the
  // pulse owner is the fresh winner or the latched owner respectively.
  always_comb begin
    gnt_next = '0;
    ack_next = '0;
    if (state_next == GRANT)  gnt_next[winner] = 1'b1;
    if (state_next == COMMIT) ack_next[owner]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt <= '0;
      ack <= '0;
    end else begin
      gnt <= gnt_next;
      ack <= ack_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= '0;
      ptr   <= PTR_RST;
      q     <= '0;
    end else begin
      if (state == IDLE && pick_valid) owner <= winner;
      if (state == GRANT && owner_req) begin
        q   <= wdata[int'(owner)*WIDTH +: WIDTH];
        ptr <= owner;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed and random checks of dff_bank_arbiter against a transaction-level
// reference model and an expected grant-order queue.
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic [1:0]            owner;
  logic [1:0]            fsm_state;

  int errors = 0;
  int checks = 0;
  int ack_count = 0;

  // Reference model: phase 0 = waiting, 1 = granted, 2 = acknowledging.
  int              m_phase;
  int              m_last;
  int              m_owner;
  logic [WIDTH-1:0] m_q;

  logic [1:0] exp_q[$];

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wdata     (wdata),
    .gnt       (gnt),
    .ack       (ack),
    .q         (q),
    .busy      (busy),
    .owner     (owner),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = NREQ - 1;
    m_owner = 0;
    m_q     = '0;
  endtask

  task automatic model_edge();
    case (m_phase)
      0: begin
        for (int k = 1; k <= NREQ; k++) begin
          if (m_phase == 0 && req[(m_last + k) % NREQ]) begin
            m_owner = (m_last + k) % NREQ;
            m_phase = 1;
          end
        end
      end
      1: begin
        if (req[m_owner]) begin
          m_q     = wdata[m_owner*WIDTH +: WIDTH];
          m_last  = m_owner;
          m_phase = 2;
        end else begin
          m_phase = 0;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check_outputs();
    logic [NREQ-1:0] one;
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_ack;
    logic [1:0]      e_ord;
    one   = 1;
    e_gnt = (m_phase == 1) ? (one << m_owner) : '0;
    e_ack = (m_phase == 2) ? (one << m_owner) : '0;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("q", 32'(q), 32'(m_q));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("state", 32'(fsm_state), 32'(m_phase));
    chk("gnt_ack_excl", 32'(gnt & ack), 32'd0);
    if (m_phase != 0) chk("owner", 32'(owner), 32'(m_owner));
    if (ack !== '0) ack_count++;
    if (gnt !== '0 && exp_q.size() > 0) begin
      e_ord = exp_q.pop_front();
      chk("gnt_order", 32'(onehot_idx(gnt)), 32'(e_ord));
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1 after the rise.
  task automatic step(input logic [NREQ-1:0] r);
    req = r;
    @(posedge clk);
    model_edge();
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    req = '0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_owner", 32'(owner), 32'd0);
    @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    model_reset();
    @(negedge clk);

    // Reset, then a single write from requester 0.
    hold_reset();
    wdata[7:0] = 8'hA5;
    step(4'b0001);
    chk("t1_gnt", 32'(gnt), 32'h1);
    step(4'b0001);
    chk("t1_q", 32'(q), 32'hA5);
    chk("t1_ack", 32'(ack), 32'h1);
    step(4'b0000);
    chk("t1_busy", 32'(busy), 32'd0);

    // All requesters held: order 0,1,2,3,0 with a grant every third cycle.
    hold_reset();
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 15; i++) step(4'b1111);
    chk("t2_drain", 32'(exp_q.size()), 32'd0);
    chk("t2_q_last", 32'(q), 32'h10);

    // Requester 2 aborts in GRANT and wins again on re-request.
    hold_reset();
    wdata = 32'($urandom);
    exp_q = '{2'd1, 2'd2, 2'd2};
    step(4'b0010);
    step(4'b0010);
    step(4'b0000);
    step(4'b0100);
    wdata = 32'($urandom);
    step(4'b0000);
    chk("t3_abort_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) step(4'b1111);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of requester 1's GRANT cycle.
    hold_reset();
    wdata = 32'($urandom);
    step(4'b0001);
    step(4'b0001);
    step(4'b0000);
    step(4'b0010);
    rst = 1'b0;
    #1;
    model_reset();
    chk("t4_q_zero", 32'(q), 32'd0);
    chk("t4_gnt_zero", 32'(gnt), 32'd0);
    check_outputs();
    hold_reset();
    exp_q = '{2'd0};
    for (int i = 0; i < 3; i++) step(4'b1111);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // Requester 3 arrives while requester 1 is in COMMIT.
    hold_reset();
    ack_count = 0;
    exp_q = '{2'd1, 2'd3};
    step(4'b0010);
    step(4'b0010);
    step(4'b1010);
    step(4'b1000);
    step(4'b1000);
    step(4'b0000);
    chk("t5_acks", 32'(ack_count), 32'd2);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // Only requester 0: ten transactions in thirty cycles.
    hold_reset();
    ack_count = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(2'd0);
    for (int i = 0; i < 30; i++) begin
      wdata = 32'($urandom);
      step(4'b0001);
    end
    chk("t6_acks", 32'(ack_count), 32'd10);
    chk("t6_drain", 32'(exp_q.size()), 32'd0);

    // Random request levels and data.
    hold_reset();
    exp_q.delete();
    begin
      logic [NREQ-1:0] r;
      r = '0;
      for (int i = 0; i < 400; i++) begin
        for (int b = 0; b < NREQ; b++)
          if ($urandom_range(7, 0) == 0) r[b] = ~r[b];
        wdata = 32'($urandom);
        step(r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin controller that shares a single WIDTH-bit storage register, built from D flip-flops, among NREQ requesters. It performs one write per grant using a three-state req/gnt/ack handshake, so only one requester writes per transaction. It sits between the requester blocks and the shared flip-flop bank, and drives the bank's value out on `q`.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 8: width of the shared register.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `req`  in  NREQ  per-requester write request, level-held.
- `wdata`  in  NREQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH].
- `gnt`  out  NREQ  one-hot grant, high for exactly one cycle per transaction.
- `ack`  out  NREQ  one-hot write-done pulse, one cycle.
- `q`  out  WIDTH  current shared register contents.
- `busy`  out  1  high whenever state is not IDLE.
- `owner`  out  clog2(NREQ)  index of the requester being served; valid while `busy`.

## Operation
- FSM states: IDLE, GRANT, COMMIT.
- IDLE, any `req` high:
  - Select the winner by round robin. Search from (ptr+1) mod NREQ upward, wrapping; ptr = last successfully served index.
  - Latch the winner into `owner` and go to GRANT.
- IDLE, no `req`: stay in IDLE.
- GRANT:
  - `gnt[owner]`=1.
  - If `req[owner]` is still 1 at the closing edge: `q` <= wdata slice of `owner`, ptr <= owner, go to COMMIT.
  - If `req[owner]` has dropped: abort. `q` and ptr are unchanged, no ack, return to IDLE.
- COMMIT: `ack[owner]`=1, then always return to IDLE.
- A requester deasserts `req` in the cycle after `ack`. If `req` is still high in IDLE, it is a fresh request and competes normally under round robin.
- Requests raised while `busy` wait. No request is lost while its `req` stays high.
- Fairness: a requester held continuously is served within NREQ transactions.
- `gnt` and `ack` are never both non-zero in the same cycle.
- `gnt` and `ack` are registered outputs with no combinational path from `req`.

## Timing
- Reset (rst=0, takes effect immediately, asynchronously):
  - state=IDLE; `q`=0, `gnt`=0, `ack`=0, `busy`=0, `owner`=0.
  - ptr=NREQ-1, so requester 0 wins first.
- Reset mid-transaction aborts it: no write and no ack. If reset hits during GRANT, `q` reads 0 after reset.
- Latency, with `req` first seen high in IDLE in cycle 0:
  - cycle 1: `gnt`, `busy`.
  - end of cycle 1: `q` updated.
  - cycle 2: `ack`.
  - cycle 3: IDLE; new arbitration possible, next `gnt` in cycle 4.
- Throughput: one write per 3 cycles when requests arrive back-to-back from IDLE.
- Simultaneous requests in the same IDLE cycle are resolved by the round-robin order only. There is no fixed priority except immediately after reset.
- `wdata` of the owner is sampled only at the GRANT→COMMIT edge and may change at any other time.

## Structure
- Package `dff_arb_pkg`:
  - state encoding IDLE=2'd0, GRANT=2'd1, COMMIT=2'd2.
  - `IDX_W` = clog2(NREQ).
  - the ptr reset value.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs `req` and `ptr`; outputs `winner` index and `valid`.
- FSM, ptr, owner and the `q` register live in the top module.

## Test plan
- Reset, then req=4'b0001 with wdata[0]=8'hA5 → gnt=0001 in cycle 1, q=8'hA5 after the cycle-1 edge, ack=0001 in cycle 2, busy low in cycle 3.
- req=4'b1111 held continuously, wdata[i]=8'h10+i → grant order 0,1,2,3,0; `q` sequence 10,11,12,13,10; gnt pulses spaced 3 cycles apart.
- Requester 2 drops req during its GRANT cycle → no ack, `q` unchanged, next grant goes to requester 2 again if it re-requests before the others are served.
- rst driven low in the middle of GRANT of requester 1 → outputs zero immediately, `q`=0, and the first grant after reset goes to requester 0.
- req[3] rises while requester 1 is in COMMIT → requester 3 is granted in the cycle after IDLE; no lost or duplicate ack.
- Only req[0] held high for 10 transactions → served every 3 cycles, ack count = 10, other gnt bits never set.
